// File: rtl/cache_assoc_wb.sv
// cache_assoc_wb: N-way set-associative write-back, write-allocate data cache
// with FIFO/LRU replacement, byte-enabled writes, full flush and hit/miss counters.
module cache_assoc_wb #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN  = 3,
  parameter int TAG_ADDR_LEN  = 6,
  parameter int WAY_CNT       = 4,
  parameter int WAY_ADDR_LEN  = 4,
  parameter int POLICY        = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [31:0]                            addr,
  input  logic                                   rd_req,
  input  logic                                   wr_req,
  input  logic [31:0]                            wr_data,
  input  logic [3:0]                             wr_be,
  output logic [31:0]                            rd_data,
  output logic                                   miss,
  input  logic                                   flush_req,
  output logic                                   flush_done,
  output logic [31:0]                            hit_cnt,
  output logic [31:0]                            miss_cnt,
  output logic                                   mem_rd_req,
  output logic                                   mem_wr_req,
  output logic [TAG_ADDR_LEN+SET_ADDR_LEN-1:0]   mem_addr,
  output logic [32*(1<<LINE_ADDR_LEN)-1:0]       mem_wr_line,
  input  logic [32*(1<<LINE_ADDR_LEN)-1:0]       mem_rd_line,
  input  logic                                   mem_gnt
);
  localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;
  localparam int SET_SIZE  = 1 << SET_ADDR_LEN;
  localparam int WI        = WAY_CNT > 1 ? $clog2(WAY_CNT) : 1;
  localparam int TOP       = TAG_ADDR_LEN + SET_ADDR_LEN + LINE_ADDR_LEN + 2;
  typedef enum logic [2:0] {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK, FLUSH_SCAN, FLUSH_WB} state_t;
  state_t state;
  logic [31:0]              data_mem [SET_SIZE][WAY_CNT][LINE_SIZE];
  logic [TAG_ADDR_LEN-1:0]  tag_mem  [SET_SIZE][WAY_CNT];
  logic                     valid    [SET_SIZE][WAY_CNT];
  logic                     dirty    [SET_SIZE][WAY_CNT];
  logic [WAY_ADDR_LEN-1:0]  age      [SET_SIZE][WAY_CNT];
  logic [WI-1:0]            fifo_ptr [SET_SIZE];
  logic [LINE_ADDR_LEN-1:0] word_sel;
  logic [SET_ADDR_LEN-1:0]  set_sel, r_set, scan_set, acc_set, wl_set;
  logic [TAG_ADDR_LEN-1:0]  tag_sel, r_tag;
  logic [WI-1:0]            hit_way, inv_way, max_way, victim, v_way, scan_way, acc_way, wl_way;
  logic                     hit, inv_found, req, refilled, acc_en, flush_step, scan_last, scan_dirty;
  logic                     unused_addr;
  assign word_sel    = addr[LINE_ADDR_LEN+1:2];
  assign set_sel     = addr[SET_ADDR_LEN+LINE_ADDR_LEN+1:LINE_ADDR_LEN+2];
  assign tag_sel     = addr[TOP-1:SET_ADDR_LEN+LINE_ADDR_LEN+2];
  assign unused_addr = ^{addr[31:TOP], addr[1:0]};
  assign req         = rd_req | wr_req;
  assign miss        = req & ~(hit & state == IDLE);
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    inv_found = 1'b0;
    inv_way = '0;
    max_way = '0;
    for (int w = WAY_CNT - 1; w >= 0; w--) begin
      if (valid[set_sel][w] && tag_mem[set_sel][w] == tag_sel) begin
        hit = 1'b1;
        hit_way = WI'(w);
      end
      if (!valid[set_sel][w]) begin
        inv_found = 1'b1;
        inv_way = WI'(w);
      end
      if (age[set_sel][w] == WAY_ADDR_LEN'(WAY_CNT - 1)) max_way = WI'(w);
    end
  end
  assign victim     = inv_found ? inv_way : (POLICY == 0 ? fifo_ptr[set_sel] : max_way);
  assign acc_en     = (state == IDLE && hit && req) || (state == SWAP_IN && mem_gnt);
  assign acc_set    = state == IDLE ? set_sel : r_set;
  assign acc_way    = state == IDLE ? hit_way : v_way;
  assign scan_dirty = valid[scan_set][scan_way] && dirty[scan_set][scan_way];
  assign scan_last  = scan_set == '1 && scan_way == WI'(WAY_CNT - 1);
  assign flush_step = (state == FLUSH_SCAN && !scan_dirty) || (state == FLUSH_WB && mem_gnt);
  // Memory port is pure state decode so reset clears requests without waiting for a clock.
  assign mem_rd_req = state == SWAP_IN;
  assign mem_wr_req = state == SWAP_OUT || state == FLUSH_WB;
  assign mem_addr   = state == SWAP_OUT ? {tag_mem[r_set][v_way], r_set} :
                      state == SWAP_IN  ? {r_tag, r_set} :
                      state == FLUSH_WB ? {tag_mem[scan_set][scan_way], scan_set} : '0;
  assign wl_set     = state == FLUSH_WB ? scan_set : r_set;
  assign wl_way     = state == FLUSH_WB ? scan_way : v_way;
  always_comb begin
    mem_wr_line = '0;
    for (int i = 0; i < LINE_SIZE; i++) mem_wr_line[32*i +: 32] = data_mem[wl_set][wl_way][i];
  end
  always_ff @(posedge clk) begin
    if (state == IDLE && hit && wr_req && !rd_req)
      for (int b = 0; b < 4; b++)
        if (wr_be[b]) data_mem[set_sel][hit_way][word_sel][8*b +: 8] <= wr_data[8*b +: 8];
    if (state == SWAP_IN && mem_gnt)
      for (int i = 0; i < LINE_SIZE; i++) data_mem[r_set][v_way][i] <= mem_rd_line[32*i +: 32];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rd_data <= '0;
      hit_cnt <= '0;
      miss_cnt <= '0;
      flush_done <= 1'b0;
      refilled <= 1'b0;
      v_way <= '0;
      r_tag <= '0;
      r_set <= '0;
      scan_set <= '0;
      scan_way <= '0;
      for (int s = 0; s < SET_SIZE; s++) begin
        fifo_ptr[s] <= '0;
        for (int w = 0; w < WAY_CNT; w++) begin
          valid[s][w] <= 1'b0;
          dirty[s][w] <= 1'b0;
          tag_mem[s][w] <= '0;
          age[s][w] <= WAY_ADDR_LEN'(w);
        end
      end
    end else begin
      flush_done <= 1'b0;
      if (acc_en)
        for (int w = 0; w < WAY_CNT; w++)
          age[acc_set][w] <= WI'(w) == acc_way ? '0 :
                             age[acc_set][w] < age[acc_set][acc_way] ? age[acc_set][w] + WAY_ADDR_LEN'(1) :
                             age[acc_set][w];
      case (state)
        IDLE:
          if (req && hit) begin
            if (rd_req) rd_data <= data_mem[set_sel][hit_way][word_sel];
            else dirty[set_sel][hit_way] <= 1'b1;
            refilled <= 1'b0;
            hit_cnt <= refilled ? hit_cnt : hit_cnt + 32'd1;
          end else if (req) begin
            v_way <= victim;
            r_tag <= tag_sel;
            r_set <= set_sel;
            miss_cnt <= miss_cnt + 32'd1;
            state <= valid[set_sel][victim] && dirty[set_sel][victim] ? SWAP_OUT : SWAP_IN;
          end else if (flush_req) begin
            scan_set <= '0;
            scan_way <= '0;
            state <= FLUSH_SCAN;
          end
        SWAP_OUT: if (mem_gnt) state <= SWAP_IN;
        SWAP_IN:
          if (mem_gnt) begin
            tag_mem[r_set][v_way] <= r_tag;
            valid[r_set][v_way] <= 1'b1;
            dirty[r_set][v_way] <= 1'b0;
            refilled <= 1'b1;
            state <= SWAP_IN_OK;
          end
        SWAP_IN_OK: begin
          fifo_ptr[r_set] <= fifo_ptr[r_set] == WI'(WAY_CNT - 1) ? '0 : fifo_ptr[r_set] + WI'(1);
          state <= IDLE;
        end
        FLUSH_SCAN, FLUSH_WB: begin
          if (state == FLUSH_WB && mem_gnt) dirty[scan_set][scan_way] <= 1'b0;
          if (flush_step) begin
            state <= scan_last ? IDLE : FLUSH_SCAN;
            flush_done <= scan_last;
            scan_way <= scan_way == WI'(WAY_CNT - 1) ? '0 : scan_way + WI'(1);
            scan_set <= scan_way == WI'(WAY_CNT - 1) ? scan_set + SET_ADDR_LEN'(1) : scan_set;
          end else if (state == FLUSH_SCAN) state <= FLUSH_WB;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_assoc_wb.sv
// tb_cache_assoc_wb: directed bench for cache_assoc_wb; instance 0 uses LRU, instance 1 FIFO,
// each backed by its own line memory model that answers after a short latency.
module tb_cache_assoc_wb;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wr_data;
  logic [3:0]  wr_be;
  logic [1:0]  rd_req_v, wr_req_v, flush_req_v, miss_v, flush_done_v;
  logic [31:0] rd_data_v [2];
  logic [31:0] hit_cnt_v [2];
  logic [31:0] miss_cnt_v [2];
  int checks = 0, passes = 0, fails = 0;
  logic [31:0] exp_q [$];
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [8:0] ln, input logic [2:0] w);
    return {8'hC5, 7'd0, ln, 5'd0, w};
  endfunction

  function automatic logic [31:0] iw(input logic [31:0] a);
    return init_word(a[13:5], a[4:2]);
  endfunction

  for (genvar p = 0; p < 2; p++) begin : g
    logic         mem_rd_req, mem_wr_req, gnt;
    logic [8:0]   mem_addr, last_wr_addr;
    logic [255:0] mem_wr_line, mem_rd_line;
    logic [255:0] model [512];
    logic         last_was_wr, rd_after_wr, overlap;
    logic [31:0]  last_wr_w0, last_wr_w1;
    int           dly, rd_cnt, wr_cnt;
    cache_assoc_wb #(.POLICY(1 - p)) u (
      .clk(clk), .rst(rst), .addr(addr), .rd_req(rd_req_v[p]), .wr_req(wr_req_v[p]),
      .wr_data(wr_data), .wr_be(wr_be), .rd_data(rd_data_v[p]), .miss(miss_v[p]),
      .flush_req(flush_req_v[p]), .flush_done(flush_done_v[p]), .hit_cnt(hit_cnt_v[p]),
      .miss_cnt(miss_cnt_v[p]), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
      .mem_addr(mem_addr), .mem_wr_line(mem_wr_line), .mem_rd_line(mem_rd_line), .mem_gnt(gnt)
    );
    initial begin
      gnt = 1'b0; mem_rd_line = '0; dly = 0; rd_cnt = 0; wr_cnt = 0;
      last_was_wr = 1'b0; rd_after_wr = 1'b0; overlap = 1'b0;
      last_wr_addr = '0; last_wr_w0 = '0; last_wr_w1 = '0;
      for (int l = 0; l < 512; l++)
        for (int w = 0; w < 8; w++) model[l][32*w +: 32] = init_word(9'(l), 3'(w));
    end
    always @(negedge clk) begin
      if (mem_rd_req && mem_wr_req) overlap = 1'b1;
      if (gnt || !(mem_rd_req || mem_wr_req)) begin
        gnt = 1'b0;
        dly = 0;
      end else if (dly < 2) dly++;
      else begin
        gnt = 1'b1;
        dly = 0;
        if (mem_rd_req) begin
          mem_rd_line = model[mem_addr];
          rd_cnt++;
          rd_after_wr = last_was_wr;
          last_was_wr = 1'b0;
        end else begin
          model[mem_addr] = mem_wr_line;
          wr_cnt++;
          last_wr_addr = mem_addr;
          last_wr_w0 = mem_wr_line[31:0];
          last_wr_w1 = mem_wr_line[63:32];
          last_was_wr = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rd_req_v = '0; wr_req_v = '0; flush_req_v = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Holds the request until miss drops, then lets exactly one completing edge pass.
  task automatic go(input int p, input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] be);
    int n = 0;
    addr = a; wr_data = d; wr_be = be;
    rd_req_v[p] = !w; wr_req_v[p] = w;
    #1;
    while (miss_v[p] && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("stall_bound", 32'(miss_v[p]), 32'd0);
    @(posedge clk);
    #1;
    rd_req_v = '0; wr_req_v = '0;
    @(negedge clk);
  endtask

  task automatic rd(input int p, input logic [31:0] a, input logic [31:0] exp);
    exp_q.push_back(exp);
    go(p, a, 1'b0, 32'd0, 4'h0);
    chk($sformatf("rd_data@%h", a), rd_data_v[p], exp_q.pop_front());
  endtask

  task automatic wr(input int p, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    go(p, a, 1'b1, d, be);
  endtask

  initial begin
    logic [31:0] lru_seq [7];
    logic [31:0] fifo_seq [7];
    int w0, r0, n;
    logic [31:0] h0;
    lru_seq  = '{32'h000, 32'h100, 32'h200, 32'h300, 32'h000, 32'h400, 32'h100};
    fifo_seq = '{32'h000, 32'h100, 32'h200, 32'h300, 32'h000, 32'h400, 32'h000};
    addr = '0; wr_data = '0; wr_be = '0;
    do_reset();
    chk("rst_rd_data", rd_data_v[0], 32'd0);
    chk("rst_hit_cnt", hit_cnt_v[0], 32'd0);
    chk("rst_miss_cnt", miss_cnt_v[0], 32'd0);
    chk("rst_mem_addr", 32'(g[0].mem_addr), 32'd0);
    chk("rst_flush_done", 32'(flush_done_v[0]), 32'd0);
    foreach (lru_seq[i]) rd(0, lru_seq[i], iw(lru_seq[i]));
    chk("lru_miss_cnt", miss_cnt_v[0], 32'd6);
    chk("lru_hit_cnt", hit_cnt_v[0], 32'd1);
    rd(0, 32'h000, iw(32'h000));
    chk("lru_tag0_kept_hit", hit_cnt_v[0], 32'd2);
    chk("lru_tag0_kept_miss", miss_cnt_v[0], 32'd6);
    foreach (fifo_seq[i]) rd(1, fifo_seq[i], iw(fifo_seq[i]));
    chk("fifo_miss_cnt", miss_cnt_v[1], 32'd6);
    chk("fifo_hit_cnt", hit_cnt_v[1], 32'd1);

    do_reset();
    wr(0, 32'h004, 32'hAABBCCDD, 4'hF);
    wr(0, 32'h004, 32'h11223344, 4'b0101);
    rd(0, 32'h004, 32'hAA22CC44);
    wr(0, 32'h000, 32'hDEADBEEF, 4'hF);
    rd(0, 32'h100, iw(32'h100));
    rd(0, 32'h200, iw(32'h200));
    rd(0, 32'h300, iw(32'h300));
    w0 = g[0].wr_cnt; r0 = g[0].rd_cnt;
    rd(0, 32'h400, iw(32'h400));
    chk("wb_count", 32'(g[0].wr_cnt - w0), 32'd1);
    chk("wb_addr", 32'(g[0].last_wr_addr), 32'd0);
    chk("wb_word0", g[0].last_wr_w0, 32'hDEADBEEF);
    chk("wb_word1_be", g[0].last_wr_w1, 32'hAA22CC44);
    chk("wb_before_refill", 32'(g[0].rd_after_wr), 32'd1);
    chk("refill_count", 32'(g[0].rd_cnt - r0), 32'd1);
    rd(0, 32'h000, 32'hDEADBEEF);

    do_reset();
    wr(0, 32'h000, 32'h12345678, 4'hF);
    wr(0, 32'h0A0, 32'h0BADF00D, 4'hF);
    w0 = g[0].wr_cnt; r0 = g[0].rd_cnt;
    flush_req_v[0] = 1'b1;
    n = 0;
    while (!flush_done_v[0] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("flush_done_pulse", 32'(flush_done_v[0]), 32'd1);
    flush_req_v[0] = 1'b0;
    chk("flush_wb_count", 32'(g[0].wr_cnt - w0), 32'd2);
    chk("flush_last_addr", 32'(g[0].last_wr_addr), 32'd5);
    @(negedge clk);
    chk("flush_done_one_cycle", 32'(flush_done_v[0]), 32'd0);
    h0 = hit_cnt_v[0];
    rd(0, 32'h0A0, 32'h0BADF00D);
    chk("post_flush_hit", hit_cnt_v[0], h0 + 32'd1);
    chk("post_flush_no_rd", 32'(g[0].rd_cnt - r0), 32'd0);
    chk("post_flush_no_wr", 32'(g[0].wr_cnt - w0), 32'd2);

    addr = 32'h300;
    rd_req_v[0] = 1'b1;
    n = 0;
    @(posedge clk);
    #2;
    while (!g[0].mem_rd_req && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("swap_in_reached", 32'(g[0].mem_rd_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_rd_req", 32'(g[0].mem_rd_req), 32'd0);
    chk("async_rst_mem_addr", 32'(g[0].mem_addr), 32'd0);
    rd_req_v = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_hit_cnt", hit_cnt_v[0], 32'd0);
    chk("rst2_miss_cnt", miss_cnt_v[0], 32'd0);
    chk("rst2_rd_data", rd_data_v[0], 32'd0);
    r0 = g[0].rd_cnt;
    rd(0, 32'h0A0, 32'h0BADF00D);
    chk("rst2_first_miss", miss_cnt_v[0], 32'd1);
    chk("rst2_first_hit_cnt", hit_cnt_v[0], 32'd0);
    chk("rst2_refill", 32'(g[0].rd_cnt - r0), 32'd1);
    chk("no_rd_wr_overlap", 32'(g[0].overlap | g[1].overlap), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
